// File: rtl/buf_seq_pkg.sv
// Shared definitions for the operand-buffer sequencer: buffer command encoding,
// sequencer FSM states, default geometry and the tile-length legality check.
package buf_seq_pkg;

    localparam int unsigned DEPTH_DEF  = 16384;
    localparam int unsigned ADDR_W_DEF = 14;

    // Command presented to the operand buffer each cycle
    typedef enum logic [1:0] {
        BUF_NOP    = 2'b00,
        BUF_STORE  = 2'b01,
        BUF_STREAM = 2'b10
    } buf_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StActive,
        StDone
    } seq_state_e;

    // A tile must hold whole pairs and fit in the buffer
    function automatic logic cfg_legal(input logic [31:0] words, input int unsigned depth);
        return (words[0] == 1'b0) && (words <= depth);
    endfunction

endpackage

// File: rtl/seq_arbiter.sv
// Per-cycle arbitration between host stores and array pair requests.
// Stream wins: a granted pair holds host_ready low that cycle, so the buffer sees
// at most one command per cycle. Also registers the one-cycle buffer read latency
// into stream_valid.
module seq_arbiter #(
    parameter int unsigned CNT_W = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stream_en,
    input  logic             stream_req,
    input  logic [CNT_W-1:0] occupancy,
    input  logic             load_en,
    input  logic             host_valid,
    input  logic             full,
    input  logic             loads_left,
    output logic             grant,
    output logic             host_ready,
    output logic             accept,
    output logic             stream_valid
);

    logic stream_valid_q;

    // Grant only when a whole pair is resident; host gets the slot otherwise
    always_comb begin
        grant      = stream_en & stream_req & (occupancy >= CNT_W'(2));
        host_ready = load_en & ~grant & ~full & loads_left;
        accept     = host_valid & host_ready;
    end

    // Buffer registers data_out, so the pair is valid one cycle after its grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stream_valid_q <= 1'b0;
        end else begin
            stream_valid_q <= grant;
        end
    end

    assign stream_valid = stream_valid_q;

endmodule

// File: rtl/buffer_sequencer.sv
// Tile-level controller for the operand buffer feeding the systolic array.
// Admits cfg_words host words into the buffer, then serves 64b pair requests,
// tracking occupancy and pulsing done at tile end.
// Build option BUF_SEQ_OVERLAP_EN: loading and streaming share one ACTIVE state so
// the host refills while the array drains; without it the tile is strictly
// LOAD then STREAM.
module buffer_sequencer
    import buf_seq_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_words,
    input  logic              host_valid,
    input  logic [31:0]       host_data,
    output logic              host_ready,
    input  logic              stream_req,
    output logic              stream_valid,
    output logic [1:0]        buf_state,
    output logic [31:0]       buf_data_in,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [CNT_W-1:0]  occupancy,
    output logic              empty,
    output logic              full,
    output logic              done,
    output logic              cfg_err
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  occ_q, loaded_q, streamed_q, len_q;
    logic              done_q, cfg_err_q;

    logic load_en, stream_en, loads_left, grant, accept, grant_last;

`ifdef BUF_SEQ_OVERLAP_EN
    localparam seq_state_e RunState = StActive;
    assign load_en   = (state_q == StActive);
    assign stream_en = (state_q == StActive);
`else
    localparam seq_state_e RunState = StLoad;
    assign load_en   = (state_q == StLoad);
    assign stream_en = (state_q == StStream);
`endif

    assign loads_left = (loaded_q < len_q);
    assign grant_last = grant && ((streamed_q + CNT_W'(2)) == len_q);

    seq_arbiter #(
        .CNT_W(CNT_W)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .stream_en   (stream_en),
        .stream_req  (stream_req),
        .occupancy   (occ_q),
        .load_en     (load_en),
        .host_valid  (host_valid),
        .full        (full),
        .loads_left  (loads_left),
        .grant       (grant),
        .host_ready  (host_ready),
        .accept      (accept),
        .stream_valid(stream_valid)
    );

    // Buffer command for this cycle; address and data are zero when idle
    always_comb begin
        buf_state   = BUF_NOP;
        buf_addr    = '0;
        buf_data_in = '0;
        if (grant) begin
            buf_state = BUF_STREAM;
            buf_addr  = rd_ptr_q;
        end else if (accept) begin
            buf_state   = BUF_STORE;
            buf_addr    = wr_ptr_q;
            buf_data_in = host_data;
        end
    end

    // Sequencer FSM with pointers, occupancy and pulse outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            loaded_q   <= '0;
            streamed_q <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            // Pointers wrap naturally at DEPTH because they are exactly ADDR_W wide
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                loaded_q <= loaded_q + CNT_W'(1);
                occ_q    <= occ_q + CNT_W'(1);
            end else if (grant) begin
                rd_ptr_q   <= rd_ptr_q + ADDR_W'(2);
                streamed_q <= streamed_q + CNT_W'(2);
                occ_q      <= occ_q - CNT_W'(2);
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        loaded_q   <= '0;
                        streamed_q <= '0;
                        len_q      <= cfg_words;
                        if (!cfg_legal(32'(cfg_words), DEPTH)) begin
                            cfg_err_q <= 1'b1;
                        end else if (cfg_words == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RunState;
                        end
                    end
                end
                StLoad: begin
                    if (accept && ((loaded_q + CNT_W'(1)) == len_q)) begin
                        state_q <= StStream;
                    end
                end
                StStream, StActive: begin
                    // Final pair implies every word was loaded, so this ends the tile
                    if (grant_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign occupancy = occ_q;
    assign empty     = (occ_q == '0);
    assign full      = (occ_q == CNT_W'(DEPTH));
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule
